// File: rtl/ft245_ram_uploader_pkg.sv
// Shared types and constants for the FT245 capture-RAM uploader.
// Holds the upload FSM state encoding and the byte lane selector.
package ft245_ram_uploader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_TXE_WAIT,
    ST_WR_HI,
    ST_WR_LO,
    ST_DONE
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int CNT_W          = 8;

  // Little-endian lane select: lane 0 is bits [7:0].
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

endpackage

// File: rtl/ft245_ram_uploader_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
// RESET_VAL lets active-low inputs come out of reset in their inactive state.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q;

  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      meta_q   <= RESET_VAL;
      sync_out <= RESET_VAL;
    end else begin
      meta_q   <= async_in;
      sync_out <= meta_q;
    end
  end

endmodule

// File: rtl/ft245_ram_uploader.sv
// Reads a full capture out of the dual-port RAM after TURN_DONE and streams it
// little-endian, one byte per WR strobe, over the FT245 asynchronous write FIFO.
module ft245_ram_uploader
  import ft245_ram_uploader_pkg::*;
#(
  parameter int ADDR_WIDTH  = 11,
  parameter int SAMPLE_NUM  = 2048,
  parameter int RAM_LATENCY = 1,
  parameter int WR_PULSE    = 3,
  parameter int WR_GAP      = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  TURN_DONE,
  input  logic                  AUTO_REARM,
  output logic [ADDR_WIDTH-1:0] RAM_RD_ADDR,
  input  logic [31:0]           RAM_DATA_IN,
  input  logic                  FT_TXE_N,
  output logic                  FT_WR,
  output logic [7:0]            FT_DATA,
  output logic                  FT_DATA_OE,
  output logic                  BUSY,
  output logic                  UPLOAD_DONE,
  output logic                  START_TURN,
  output logic                  OVERRUN
);

  localparam logic [CNT_W-1:0]      RD_LAST   = CNT_W'(RAM_LATENCY);
  localparam logic [CNT_W-1:0]      HI_LAST   = CNT_W'(WR_PULSE - 1);
  localparam logic [CNT_W-1:0]      LO_LAST   = CNT_W'(WR_GAP - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(SAMPLE_NUM - 1);
  localparam logic [1:0]            BYTE_LAST = 2'(BYTES_PER_WORD - 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [1:0]              byte_idx_q, byte_idx_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             word_q, word_d;
  logic [7:0]              ft_data_q, ft_data_d;
  logic                    overrun_q, overrun_d;
  logic                    txe_s;

  sync_2ff #(.RESET_VAL(1'b1)) u_txe_sync (
    .CLK      (CLK),
    .RST      (RST),
    .async_in (FT_TXE_N),
    .sync_out (txe_s)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    byte_idx_d = byte_idx_q;
    addr_d     = addr_q;
    word_d     = word_q;
    ft_data_d  = ft_data_q;
    overrun_d  = overrun_q | (TURN_DONE && state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: if (TURN_DONE) begin
        addr_d     = '0;
        byte_idx_d = '0;
        cnt_d      = '0;
        state_d    = ST_RD_WAIT;
      end
      // One extra cycle beyond RAM_LATENCY because the RAM samples the new address on the next edge.
      ST_RD_WAIT: if (cnt_q == RD_LAST) begin
        word_d    = RAM_DATA_IN;
        ft_data_d = word_byte(RAM_DATA_IN, byte_idx_q);
        state_d   = ST_TXE_WAIT;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      ST_TXE_WAIT: if (!txe_s) begin
        cnt_d   = '0;
        state_d = ST_WR_HI;
      end
      ST_WR_HI: if (cnt_q == HI_LAST) begin
        cnt_d   = '0;
        state_d = ST_WR_LO;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      // The gap outlasts the TXE synchronizer, so a FIFO-full reaction to this byte is seen in TXE_WAIT.
      ST_WR_LO: if (cnt_q == LO_LAST) begin
        cnt_d = '0;
        if (byte_idx_q != BYTE_LAST) begin
          byte_idx_d = byte_idx_q + 2'd1;
          ft_data_d  = word_byte(word_q, byte_idx_q + 2'd1);
          state_d    = ST_TXE_WAIT;
        end else if (addr_q != ADDR_LAST) begin
          byte_idx_d = '0;
          addr_d     = addr_q + ADDR_WIDTH'(1);
          state_d    = ST_RD_WAIT;
        end else begin
          state_d = ST_DONE;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      ST_DONE: begin
        addr_d  = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pad-facing strobes are registered from the next state so they never glitch on state decode.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      byte_idx_q  <= '0;
      addr_q      <= '0;
      word_q      <= '0;
      ft_data_q   <= '0;
      overrun_q   <= 1'b0;
      FT_WR       <= 1'b0;
      FT_DATA_OE  <= 1'b0;
      BUSY        <= 1'b0;
      UPLOAD_DONE <= 1'b0;
      START_TURN  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      byte_idx_q  <= byte_idx_d;
      addr_q      <= addr_d;
      word_q      <= word_d;
      ft_data_q   <= ft_data_d;
      overrun_q   <= overrun_d;
      FT_WR       <= (state_d == ST_WR_HI);
      FT_DATA_OE  <= state_d inside {ST_TXE_WAIT, ST_WR_HI, ST_WR_LO};
      BUSY        <= state_d inside {ST_RD_WAIT, ST_TXE_WAIT, ST_WR_HI, ST_WR_LO};
      UPLOAD_DONE <= (state_d == ST_DONE);
      START_TURN  <= (state_q == ST_DONE) && AUTO_REARM;
    end
  end

  assign RAM_RD_ADDR = addr_q;
  assign FT_DATA     = ft_data_q;
  assign OVERRUN     = overrun_q;

endmodule

// File: tb/tb_ft245_ram_uploader.sv
// Randomized scoreboard bench for ft245_ram_uploader with a 4-word capture RAM model
// and an FT245 model that reports FIFO-full for a random time after each byte.
module tb_ft245_ram_uploader;

  localparam int AW = 2;
  localparam int SN = 4;

  logic          CLK = 1'b0;
  logic          RST, TURN_DONE, AUTO_REARM, FT_TXE_N;
  logic [AW-1:0] RAM_RD_ADDR;
  logic [31:0]   RAM_DATA_IN;
  logic          FT_WR;
  logic [7:0]    FT_DATA;
  logic          FT_DATA_OE, BUSY, UPLOAD_DONE, START_TURN, OVERRUN;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] mem [SN];
  logic [7:0]  exp_q [$];
  int          bytes_seen = 0;
  int          done_cnt = 0;
  int          stray_cnt = 0;
  int          txe_low_run = 0;
  bit          exp_rearm = 1'b0;
  bit          txe_mode = 1'b0;
  int          d0, b0;

  always #5 CLK = ~CLK;

  ft245_ram_uploader #(
    .ADDR_WIDTH(AW), .SAMPLE_NUM(SN), .RAM_LATENCY(1), .WR_PULSE(3), .WR_GAP(3)
  ) dut (
    .CLK(CLK), .RST(RST), .TURN_DONE(TURN_DONE), .AUTO_REARM(AUTO_REARM),
    .RAM_RD_ADDR(RAM_RD_ADDR), .RAM_DATA_IN(RAM_DATA_IN), .FT_TXE_N(FT_TXE_N),
    .FT_WR(FT_WR), .FT_DATA(FT_DATA), .FT_DATA_OE(FT_DATA_OE), .BUSY(BUSY),
    .UPLOAD_DONE(UPLOAD_DONE), .START_TURN(START_TURN), .OVERRUN(OVERRUN)
  );

  // Synchronous-read capture RAM, one cycle of latency.
  always @(posedge CLK) RAM_DATA_IN <= mem[RAM_RD_ADDR];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: every word in address order, bytes little-endian.
  task automatic load_and_expect(input bit fixed);
    for (int i = 0; i < SN; i++) mem[i] = fixed ? 32'hA0B0C0D0 + i : $urandom;
    for (int i = 0; i < SN; i++)
      for (int k = 0; k < 4; k++) exp_q.push_back(8'(mem[i] >> (8 * k)));
  endtask

  // FT245 model: FIFO reports full shortly after each latched byte.
  initial forever begin
    @(negedge FT_WR);
    if (txe_mode && !RST) begin
      #1 FT_TXE_N = 1'b1;
      repeat ($urandom_range(20, 1)) @(posedge CLK);
      #1 FT_TXE_N = 1'b0;
    end
  end

  // Monitor: pops the scoreboard on each WR falling edge.
  logic       prev_wr = 1'b0;
  logic       prev_done = 1'b0;
  logic [7:0] data_at_rise = '0;
  initial forever begin
    @(negedge CLK);
    if (RST) begin
      prev_wr   = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (FT_WR && !prev_wr) begin
        data_at_rise = FT_DATA;
        check("txe_gate", 32'(txe_low_run >= 2), 1);
      end
      if (!FT_WR && prev_wr) begin
        bytes_seen++;
        check("data_stable", FT_DATA, data_at_rise);
        check("oe_during_write", FT_DATA_OE, 1);
        check("byte_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("byte", FT_DATA, exp_q.pop_front());
      end
      if (prev_done) begin
        check("start_turn", START_TURN, exp_rearm);
        check("done_width", UPLOAD_DONE, 0);
      end else if (START_TURN) begin
        stray_cnt++;
      end
      if (UPLOAD_DONE) done_cnt++;
      prev_wr   = FT_WR;
      prev_done = UPLOAD_DONE;
    end
    txe_low_run = FT_TXE_N ? 0 : txe_low_run + 1;
  end

  task automatic pulse_turn();
    @(posedge CLK); #1 TURN_DONE = 1'b1;
    @(posedge CLK); #1 TURN_DONE = 1'b0;
  endtask

  task automatic start_upload(input bit fixed, input bit auto);
    load_and_expect(fixed);
    AUTO_REARM = auto;
    exp_rearm  = auto;
    stray_cnt  = 0;
    d0 = done_cnt;
    b0 = bytes_seen;
    pulse_turn();
  endtask

  task automatic finish_upload();
    int n = 0;
    while (done_cnt == d0 && n < 5000) begin
      @(posedge CLK);
      n++;
    end
    check("upload_done_seen", done_cnt - d0, 1);
    repeat (3) @(posedge CLK);
    #1;
    check("busy_after", BUSY, 0);
    check("bytes_total", bytes_seen - b0, 4 * SN);
    check("queue_empty", exp_q.size(), 0);
    check("start_stray", stray_cnt, 0);
  endtask

  task automatic wait_bytes(input int count);
    int n = 0;
    while (bytes_seen - b0 < count && n < 2000) begin
      @(posedge CLK);
      n++;
    end
    check("bytes_reached", 32'(bytes_seen - b0 >= count), 1);
  endtask

  initial begin
    int n;
    RST = 1'b1; TURN_DONE = 1'b0; AUTO_REARM = 1'b0; FT_TXE_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_ft_wr", FT_WR, 0);
    check("rst_busy", BUSY, 0);
    check("rst_addr", RAM_RD_ADDR, 0);
    check("rst_oe", FT_DATA_OE, 0);
    check("rst_done", UPLOAD_DONE, 0);
    check("rst_start", START_TURN, 0);
    check("rst_overrun", OVERRUN, 0);
    RST = 1'b0;

    // Fixed pattern, FIFO always ready, no re-arm.
    start_upload(1'b1, 1'b0);
    finish_upload();

    // Random data with re-arm.
    start_upload(1'b0, 1'b1);
    finish_upload();

    // FIFO goes full after every byte for a random time.
    txe_mode = 1'b1;
    start_upload(1'b0, 1'b1);
    finish_upload();
    txe_mode = 1'b0;
    repeat (25) @(posedge CLK);
    #1 FT_TXE_N = 1'b0;

    // Second TURN_DONE after byte 5: flagged, upload unaffected.
    start_upload(1'b0, 1'b0);
    wait_bytes(5);
    check("overrun_before", OVERRUN, 0);
    #1 TURN_DONE = 1'b1;
    @(posedge CLK); #1 TURN_DONE = 1'b0;
    check("overrun_set", OVERRUN, 1);
    finish_upload();
    check("overrun_sticky", OVERRUN, 1);

    // Reset in the middle of word 2's first strobe, then a clean restart.
    start_upload(1'b0, 1'b0);
    wait_bytes(8);
    n = 0;
    do begin
      @(posedge CLK); #1;
      n++;
    end while (!FT_WR && n < 200);
    check("reached_wr_hi", FT_WR, 1);
    check("addr_word2", RAM_RD_ADDR, 2);
    #1 RST = 1'b1;
    #1;
    check("abort_ft_wr", FT_WR, 0);
    check("abort_busy", BUSY, 0);
    check("abort_addr", RAM_RD_ADDR, 0);
    check("abort_oe", FT_DATA_OE, 0);
    check("abort_overrun", OVERRUN, 0);
    exp_q.delete();
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    start_upload(1'b0, 1'b0);
    finish_upload();

    // FIFO full for a long time before the first byte.
    FT_TXE_N = 1'b1;
    repeat (5) @(posedge CLK);
    start_upload(1'b0, 1'b1);
    repeat (10000) @(posedge CLK);
    #1;
    check("hold_no_bytes", bytes_seen - b0, 0);
    check("hold_ft_wr", FT_WR, 0);
    check("hold_busy", BUSY, 1);
    check("hold_oe", FT_DATA_OE, 1);
    check("hold_data", FT_DATA, exp_q[0]);
    FT_TXE_N = 1'b0;
    finish_upload();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
